// File: rtl/counter_sequencer.sv
// Run/pause/direction sequencer for the display up/down counter: turns button pulses into
// registered counter controls. Optional bounce mode: define COUNTER_SEQ_AUTO_REVERSE_EN.
module counter_sequencer #(
    parameter int unsigned BIT_COUNT = 16,
    parameter int unsigned TICK_DIV  = 1000,
    parameter int unsigned MAX_COUNT = 9999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_stop,
    input  logic                 dir_toggle,
    input  logic                 clear,
    input  logic [BIT_COUNT-1:0] count,
    output logic                 cnt_reset_n,
    output logic                 cnt_enable_n,
    output logic                 cnt_up_down,
    output logic                 running
);

    localparam int unsigned         PreWidth = $clog2(TICK_DIV);
    localparam logic [PreWidth-1:0] PreLast  = PreWidth'(TICK_DIV - 1);
    localparam logic [PreWidth-1:0] PreOne   = PreWidth'(1);

    typedef enum logic {
        StStopped,
        StRunning
    } state_e;

    state_e              state_q;
    logic [PreWidth-1:0] pre_q;
    logic                dir_q;
    logic                tick;
    logic                eff_dir;
    logic                next_dir;

    assign tick    = (state_q == StRunning) && (pre_q == PreLast);
    assign eff_dir = dir_q ^ dir_toggle;

`ifdef COUNTER_SEQ_AUTO_REVERSE_EN
    localparam logic [BIT_COUNT-1:0] MaxCount = BIT_COUNT'(MAX_COUNT);

    // Reverse on the bounding tick itself so no value is repeated at either end.
    always_comb begin
        next_dir = eff_dir;
        if (!eff_dir && (count >= MaxCount)) begin
            next_dir = 1'b1;
        end else if (eff_dir && (count == '0)) begin
            next_dir = 1'b0;
        end
    end
`else
    logic unused_count;

    assign unused_count = ^count;
    assign next_dir     = eff_dir;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StStopped;
            pre_q        <= '0;
            dir_q        <= 1'b0;
            cnt_reset_n  <= 1'b0;
            cnt_enable_n <= 1'b1;
            cnt_up_down  <= 1'b0;
            running      <= 1'b0;
        end else begin
            cnt_reset_n  <= 1'b1;
            cnt_enable_n <= 1'b1;
            if (clear) begin
                state_q     <= StStopped;
                running     <= 1'b0;
                pre_q       <= '0;
                dir_q       <= 1'b0;
                cnt_up_down <= 1'b0;
                cnt_reset_n <= 1'b0;
            end else if (start_stop) begin
                // A stopping pulse swallows any coincident tick.
                state_q     <= (state_q == StStopped) ? StRunning : StStopped;
                running     <= (state_q == StStopped);
                pre_q       <= '0;
                dir_q       <= eff_dir;
                cnt_up_down <= eff_dir;
            end else if (tick) begin
                pre_q        <= '0;
                dir_q        <= next_dir;
                cnt_up_down  <= next_dir;
                cnt_enable_n <= 1'b0;
            end else begin
                dir_q       <= eff_dir;
                cnt_up_down <= eff_dir;
                if (state_q == StRunning) begin
                    pre_q <= pre_q + PreOne;
                end
            end
        end
    end

endmodule
